// File: rtl/store_split_unit_pkg.sv
// Shared store-width codes, FSM state encoding and lane-mask helper for the store split unit.
package store_split_unit_pkg;

   localparam logic [1:0] TypeSb = 2'b00;
   localparam logic [1:0] TypeSh = 2'b01;
   localparam logic [1:0] TypeSw = 2'b10;

   localparam int unsigned WideBeW = 7;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBeat0 = 2'b01,
      StBeat1 = 2'b10,
      StErr   = 2'b11
   } state_e;

   // Expands a 4-bit byte enable into a 32-bit data mask.
   function automatic logic [31:0] be_to_bitmask(input logic [3:0] be);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane placement: byte offset, width and data to the 7-bit wide enable
// and the write data of both beats, with bytes outside the enables forced to zero.
module store_lane_gen
   import store_split_unit_pkg::*;
(
   input  logic [1:0]         off_i,
   input  logic [1:0]         type_i,
   input  logic [31:0]        data_i,
   output logic               legal_o,
   output logic [WideBeW-1:0] wide_be_o,
   output logic [31:0]        beat0_data_o,
   output logic [31:0]        beat1_data_o
);

   logic [3:0]  mask;
   logic [63:0] shifted;

   always_comb begin
      mask    = 4'b0000;
      legal_o = 1'b1;
      case (type_i)
         TypeSb:  mask = 4'b0001;
         TypeSh:  mask = 4'b0011;
         TypeSw:  mask = 4'b1111;
         default: legal_o = 1'b0;
      endcase
      wide_be_o = {3'b000, mask} << off_i;
      // Upper half of the 64-bit shift is what spills into the next word.
      shifted      = {32'h0, data_i} << {off_i, 3'b000};
      beat0_data_o = shifted[31:0] & be_to_bitmask(wide_be_o[3:0]);
      beat1_data_o = shifted[63:32] & be_to_bitmask({1'b0, wide_be_o[6:4]});
   end

endmodule

// File: rtl/store_split_unit.sv
// Splits a byte/half/word store into one or two word-aligned memory beats with
// byte enables; pulses done after the final beat and err for an illegal width code.
module store_split_unit
   import store_split_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_data_i,
   input  logic [1:0]  req_type_i,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        done_o,
   output logic        err_o
);

   state_e              state_q;
   logic                mem_valid_q;
   logic [31:0]         mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [3:0]          mem_be_q;
   logic [31:0]         b1_data_q;
   logic [2:0]          b1_be_q;
   logic                done_q;
   logic                err_q;

   logic                legal;
   logic [WideBeW-1:0]  wide_be;
   logic [31:0]         beat0_data;
   logic [31:0]         beat1_data;

   store_lane_gen u_lane_gen (
      .off_i        (req_addr_i[1:0]),
      .type_i       (req_type_i),
      .data_i       (req_data_i),
      .legal_o      (legal),
      .wide_be_o    (wide_be),
      .beat0_data_o (beat0_data),
      .beat1_data_o (beat1_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         b1_data_q   <= '0;
         b1_be_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  if (legal) begin
                     // Beat 0 is loaded straight into the output registers; beat 1 waits.
                     state_q     <= StBeat0;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                     mem_wdata_q <= beat0_data;
                     mem_be_q    <= wide_be[3:0];
                     b1_data_q   <= beat1_data;
                     b1_be_q     <= wide_be[6:4];
                  end else begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end
               end
            end
            StBeat0: begin
               if (mem_ready_i) begin
                  if (b1_be_q != 3'b000) begin
                     state_q     <= StBeat1;
                     mem_addr_q  <= mem_addr_q + 32'd4;
                     mem_wdata_q <= b1_data_q;
                     mem_be_q    <= {1'b0, b1_be_q};
                  end else begin
                     state_q     <= StIdle;
                     mem_valid_q <= 1'b0;
                     mem_addr_q  <= '0;
                     mem_wdata_q <= '0;
                     mem_be_q    <= '0;
                     done_q      <= 1'b1;
                  end
               end
            end
            StBeat1: begin
               if (mem_ready_i) begin
                  state_q     <= StIdle;
                  mem_valid_q <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_be_q    <= '0;
                  done_q      <= 1'b1;
               end
            end
            StErr: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req_ready_o = rst_ni && (state_q == StIdle);
   assign mem_valid_o = mem_valid_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_store_split_unit.sv
// Bench for store_split_unit: directed and random stores checked against a byte-wise model.
module tb_store_split_unit;
   import store_split_unit_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_data_i;
   logic [1:0]  req_type_i;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        done_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   store_split_unit dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .req_type_i  (req_type_i),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic accept(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] typ);
      check("ready_before_req", {31'b0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_data_i  = data;
      req_type_i  = typ;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      req_data_i  = $urandom;
      req_type_i  = 2'($urandom);
   endtask

   task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
      check({tag, "_valid"}, {31'b0, mem_valid_o}, 32'd1);
      check({tag, "_addr"}, mem_addr_o, a);
      check({tag, "_wdata"}, mem_wdata_o, d);
      check({tag, "_be"}, {28'b0, mem_be_o}, {28'b0, be});
      check({tag, "_done"}, {31'b0, done_o}, 32'd0);
      check({tag, "_err"}, {31'b0, err_o}, 32'd0);
      check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd0);
   endtask

   // Full store: each byte goes to address addr+k; bytes sharing a word form one beat.
   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] typ,
                           input int stall);
      logic [31:0] qa[$];
      logic [31:0] qd[$];
      logic [3:0]  qb[$];
      int          nbytes;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] byte_val;
      int          s;
      nbytes = (typ == TypeSb) ? 1 : (typ == TypeSh) ? 2 : (typ == TypeSw) ? 4 : 0;
      for (int k = 0; k < nbytes; k++) begin
         a = addr + k;
         w = a & 32'hFFFF_FFFC;
         if (qa.size() == 0 || qa[$] != w) begin
            qa.push_back(w);
            qd.push_back(32'h0);
            qb.push_back(4'h0);
         end
         byte_val = (data >> (8 * k)) & 32'hFF;
         qd[$] = qd[$] | (byte_val << (8 * a[1:0]));
         qb[$] = qb[$] | (4'b0001 << a[1:0]);
      end
      accept(addr, data, typ);
      if (nbytes == 0) begin
         check("err_pulse", {31'b0, err_o}, 32'd1);
         check("err_no_valid", {31'b0, mem_valid_o}, 32'd0);
         check("err_no_done", {31'b0, done_o}, 32'd0);
         check("err_busy", {31'b0, req_ready_o}, 32'd0);
         @(negedge clk_i);
         check("err_cleared", {31'b0, err_o}, 32'd0);
         check("err_ready_back", {31'b0, req_ready_o}, 32'd1);
         return;
      end
      for (int b = 0; b < qa.size(); b++) begin
         s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         for (int j = 0; j < s; j++) begin
            mem_ready_i = 1'b0;
            check_beat($sformatf("beat%0d_stall", b), qa[b], qd[b], qb[b]);
            @(negedge clk_i);
         end
         mem_ready_i = 1'b1;
         check_beat($sformatf("beat%0d", b), qa[b], qd[b], qb[b]);
         @(negedge clk_i);
         mem_ready_i = 1'b0;
      end
      check("done_pulse", {31'b0, done_o}, 32'd1);
      check("done_no_err", {31'b0, err_o}, 32'd0);
      check("idle_no_valid", {31'b0, mem_valid_o}, 32'd0);
      check("idle_ready", {31'b0, req_ready_o}, 32'd1);
      @(negedge clk_i);
      check("done_cleared", {31'b0, done_o}, 32'd0);
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_data_i  = '0;
      req_type_i  = '0;
      mem_ready_i = 1'b0;
      #1;
      check("rst_valid", {31'b0, mem_valid_o}, 32'd0);
      check("rst_ready", {31'b0, req_ready_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      check("rst_be", {28'b0, mem_be_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("ready_after_rst", {31'b0, req_ready_o}, 32'd1);
      @(negedge clk_i);

      do_store(32'h0000_0100, 32'hDEAD_BEEF, TypeSw, 0);
      do_store(32'h0000_0203, 32'h0000_00A5, TypeSb, 0);
      do_store(32'h0000_0303, 32'h0000_1234, TypeSh, 1);
      do_store(32'hFFFF_FFFE, 32'h1122_3344, TypeSw, 3);
      do_store(32'h0000_0040, 32'h0000_0000, 2'b11, 0);

      // Reset during the second-beat stall of a split half-word.
      accept(32'h0000_0303, 32'h0000_1234, TypeSh);
      mem_ready_i = 1'b1;
      check_beat("rb_beat0", 32'h0000_0300, 32'h3400_0000, 4'b1000);
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      check_beat("rb_beat1", 32'h0000_0304, 32'h0000_0012, 4'b0001);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("rb_valid_drop", {31'b0, mem_valid_o}, 32'd0);
      check("rb_be_clear", {28'b0, mem_be_o}, 32'd0);
      check("rb_ready_low", {31'b0, req_ready_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         check("rb_no_done", {31'b0, done_o}, 32'd0);
         check("rb_no_valid", {31'b0, mem_valid_o}, 32'd0);
      end
      mem_ready_i = 1'b0;
      do_store(32'h0000_0501, 32'h0000_005A, TypeSb, 0);

      for (int n = 0; n < 60; n++) begin
         logic [1:0] t;
         t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_store($urandom, $urandom, t, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
